// File: rtl/instruction_sequencer_pkg.sv
// Shared definitions for the multi-cycle instruction sequencer: state encoding,
// mcause codes and the default reset pc.
package instruction_sequencer_pkg;

    localparam logic [31:0] DEFAULT_RESET_ADDRESS = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_HALTED,
        ST_FETCH,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_TRAP
    } seq_state_e;

    localparam logic [3:0] CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] CAUSE_INSTR_FAULT      = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL_INSTR    = 4'd2;
    localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
    localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
    localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;
    localparam logic [3:0] CAUSE_ECALL            = 4'd11;

    // Decoder inputs are only meaningful while an instruction is being worked on.
    function automatic logic decoder_live(input seq_state_e state);
        return state inside {ST_EXECUTE, ST_MEMORY, ST_WRITEBACK};
    endfunction

endpackage

// File: rtl/sequencer_watchdog.sv
// Bus-access watchdog: counts request cycles and flags the cycle in which the
// LIMIT-th consecutive cycle without an acknowledge is reached.
module sequencer_watchdog #(
    parameter int unsigned          WIDTH = 8,
    parameter logic [WIDTH-1:0]     LIMIT = 8'd255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = LIMIT - WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Combinational so the caller can let an ack in the same cycle take priority.
    assign expired = count_en && (count_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM: fetch, execute, memory, writeback and trap entry for
// one instruction at a time; owns the pc and retirement strobes.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter logic [31:0]              RESET_ADDRESS  = DEFAULT_RESET_ADDRESS,
    parameter int unsigned              TIMEOUT_WIDTH  = 8,
    parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        haltRequest,
    output logic        instrReq,
    output logic [31:0] instrAddr,
    input  logic        instrAck,
    input  logic [31:0] instrData,
    output logic [31:0] currentInstruction,
    output logic        isNOP,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic        isJAL,
    input  logic        isJALR,
    input  logic        isBranch,
    input  logic        isECALL,
    input  logic        isEBREAK,
    input  logic        isRET,
    input  logic        invalidInstruction,
    input  logic [4:0]  rdIndex,
    input  logic        jumpTaken,
    input  logic [31:0] jumpTarget,
    input  logic [31:0] retAddress,
    input  logic [31:0] trapVector,
    output logic        memReq,
    input  logic        memAck,
    input  logic        memError,
    output logic        regWriteEnable,
    output logic        retire,
    output logic        trapRequest,
    output logic [3:0]  trapCause,
    output logic [31:0] trapPC,
    output logic        halted
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        is_nop_q, is_nop_d;
    logic        instr_req_q, instr_req_d;
    logic        mem_req_q, mem_req_d;
    logic        reg_we_q, reg_we_d;
    logic        retire_q, retire_d;
    logic        trap_req_q, trap_req_d;
    logic [3:0]  trap_cause_q, trap_cause_d;
    logic [31:0] trap_pc_q, trap_pc_d;
    logic        halted_q, halted_d;

    logic        enter_trap;
    logic [3:0]  trap_code;
    logic        writes_rd;
    logic [3:0]  data_fault_cause;
    logic        wd_clear;
    logic        wd_count;
    logic        wd_expired;

    // Execute has already folded the jump kind into jumpTaken/jumpTarget.
    logic        unused_jump_kind;
    assign unused_jump_kind = isJAL ^ isJALR;

    assign writes_rd        = (rdIndex != 5'd0) && !(isStore || isBranch);
    assign data_fault_cause = isStore ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path can infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_req_d  = instr_req_q;
        mem_req_d    = mem_req_q;
        trap_cause_d = trap_cause_q;
        trap_pc_d    = trap_pc_q;
        enter_trap   = 1'b0;
        trap_code    = CAUSE_INSTR_MISALIGNED;

        case (state_q)
            ST_HALTED: begin
                if (!haltRequest) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (!instr_req_q) begin
                    // First FETCH cycle is the instruction boundary: halt or launch.
                    if (haltRequest) begin
                        state_d = ST_HALTED;
                    end else if (pc_q[1:0] != 2'b00) begin
                        enter_trap = 1'b1;
                        trap_code  = CAUSE_INSTR_MISALIGNED;
                    end else begin
                        instr_req_d = 1'b1;
                    end
                end else if (instrAck) begin
                    instr_req_d = 1'b0;
                    instr_d     = instrData;
                    state_d     = ST_EXECUTE;
                end else if (wd_expired) begin
                    instr_req_d = 1'b0;
                    enter_trap  = 1'b1;
                    trap_code   = CAUSE_INSTR_FAULT;
                end
            end
            ST_EXECUTE: begin
                if (invalidInstruction) begin
                    enter_trap = 1'b1;
                    trap_code  = CAUSE_ILLEGAL_INSTR;
                end else if (isECALL) begin
                    enter_trap = 1'b1;
                    trap_code  = CAUSE_ECALL;
                end else if (isEBREAK) begin
                    enter_trap = 1'b1;
                    trap_code  = CAUSE_BREAKPOINT;
                end else if (isLoad || isStore) begin
                    mem_req_d = 1'b1;
                    state_d   = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (memAck) begin
                    mem_req_d = 1'b0;
                    if (memError) begin
                        enter_trap = 1'b1;
                        trap_code  = data_fault_cause;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else if (wd_expired) begin
                    mem_req_d  = 1'b0;
                    enter_trap = 1'b1;
                    trap_code  = data_fault_cause;
                end
            end
            ST_WRITEBACK: begin
                pc_d    = jumpTaken ? jumpTarget : (isRET ? retAddress : pc_q + 32'd4);
                state_d = haltRequest ? ST_HALTED : ST_FETCH;
            end
            ST_TRAP: begin
                pc_d    = trapVector;
                state_d = haltRequest ? ST_HALTED : ST_FETCH;
            end
            default: begin
                state_d     = ST_FETCH;
                instr_req_d = 1'b0;
                mem_req_d   = 1'b0;
            end
        endcase

        if (enter_trap) begin
            state_d      = ST_TRAP;
            trap_cause_d = trap_code;
            trap_pc_d    = pc_q;
        end

        trap_req_d = enter_trap;
        retire_d   = (state_d == ST_WRITEBACK);
        reg_we_d   = retire_d && writes_rd;
        halted_d   = (state_d == ST_HALTED);
        is_nop_d   = !decoder_live(state_d);
    end

    assign wd_count = instr_req_q | mem_req_q;
    assign wd_clear = (state_d != state_q) | (instr_req_q & instrAck) | (mem_req_q & memAck);

    sequencer_watchdog #(
        .WIDTH (TIMEOUT_WIDTH),
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (wd_clear),
        .count_en (wd_count),
        .expired  (wd_expired)
    );

    // NOTE: sequential state is only ever updated with non-blocking assignments.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_ADDRESS;
            instr_q      <= 32'h0;
            is_nop_q     <= 1'b1;
            instr_req_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            retire_q     <= 1'b0;
            trap_req_q   <= 1'b0;
            trap_cause_q <= 4'd0;
            trap_pc_q    <= 32'h0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            is_nop_q     <= is_nop_d;
            instr_req_q  <= instr_req_d;
            mem_req_q    <= mem_req_d;
            reg_we_q     <= reg_we_d;
            retire_q     <= retire_d;
            trap_req_q   <= trap_req_d;
            trap_cause_q <= trap_cause_d;
            trap_pc_q    <= trap_pc_d;
            halted_q     <= halted_d;
        end
    end

    assign instrReq           = instr_req_q;
    assign instrAddr          = pc_q;
    assign currentInstruction = instr_q;
    assign isNOP              = is_nop_q;
    assign memReq             = mem_req_q;
    assign regWriteEnable     = reg_we_q;
    assign retire             = retire_q;
    assign trapRequest        = trap_req_q;
    assign trapCause          = trap_cause_q;
    assign trapPC             = trap_pc_q;
    assign halted             = halted_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench: the bench plays bus slave and decoder, and predicts each
// instruction's outcome (retire or trap, next pc) from the architectural rules.
module tb_instruction_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        haltRequest;
    logic        instrReq;
    logic [31:0] instrAddr;
    logic        instrAck;
    logic [31:0] instrData;
    logic [31:0] currentInstruction;
    logic        isNOP;
    logic        isLoad, isStore, isJAL, isJALR, isBranch, isECALL, isEBREAK, isRET;
    logic        invalidInstruction;
    logic [4:0]  rdIndex;
    logic        jumpTaken;
    logic [31:0] jumpTarget;
    logic [31:0] retAddress;
    logic [31:0] trapVector;
    logic        memReq;
    logic        memAck;
    logic        memError;
    logic        regWriteEnable;
    logic        retire;
    logic        trapRequest;
    logic [3:0]  trapCause;
    logic [31:0] trapPC;
    logic        halted;

    instruction_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .haltRequest        (haltRequest),
        .instrReq           (instrReq),
        .instrAddr          (instrAddr),
        .instrAck           (instrAck),
        .instrData          (instrData),
        .currentInstruction (currentInstruction),
        .isNOP              (isNOP),
        .isLoad             (isLoad),
        .isStore            (isStore),
        .isJAL              (isJAL),
        .isJALR             (isJALR),
        .isBranch           (isBranch),
        .isECALL            (isECALL),
        .isEBREAK           (isEBREAK),
        .isRET              (isRET),
        .invalidInstruction (invalidInstruction),
        .rdIndex            (rdIndex),
        .jumpTaken          (jumpTaken),
        .jumpTarget         (jumpTarget),
        .retAddress         (retAddress),
        .trapVector         (trapVector),
        .memReq             (memReq),
        .memAck             (memAck),
        .memError           (memError),
        .regWriteEnable     (regWriteEnable),
        .retire             (retire),
        .trapRequest        (trapRequest),
        .trapCause          (trapCause),
        .trapPC             (trapPC),
        .halted             (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cycle_count = 0;
    always @(posedge clk) cycle_count <= cycle_count + 1;

    typedef enum int {
        K_ALU, K_LOAD, K_STORE, K_BR_NT, K_BR_T, K_JAL, K_JALR, K_RET, K_ECALL, K_EBREAK, K_INVALID
    } kind_e;

    // flat/mlat: request cycle on which the ack is given (0 = never acknowledged)
    typedef struct {
        kind_e       kind;
        logic [4:0]  rd;
        int          flat;
        int          mlat;
        bit          merr;
        logic [31:0] tgt;
        logic [31:0] tvec;
        logic [31:0] reta;
        bit          halt_mem;
    } instr_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc;
    int          last_retire_cycle = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input kind_e k, input logic [4:0] rd, input int flat,
                                  input int mlat, input bit merr, input logic [31:0] tgt,
                                  input logic [31:0] tvec);
        instr_t t;
        t.kind = k; t.rd = rd; t.flat = flat; t.mlat = mlat; t.merr = merr;
        t.tgt = tgt; t.tvec = tvec; t.reta = 32'h0000_0200; t.halt_mem = 1'b0;
        return t;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t t;
        t.kind     = kind_e'($urandom_range(0, 10));
        t.rd       = 5'($urandom_range(0, 31));
        t.flat     = $urandom_range(1, 3);
        t.mlat     = $urandom_range(1, 4);
        t.merr     = ($urandom_range(0, 5) == 0);
        t.tgt      = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) t.tgt[1:0] = 2'($urandom_range(1, 3));
        t.tvec     = $urandom & 32'hFFFF_FFFC;
        t.reta     = $urandom & 32'hFFFF_FFFC;
        t.halt_mem = 1'b0;
        return t;
    endfunction

    task automatic idle_inputs();
        haltRequest = 0; instrAck = 0; instrData = 0; memAck = 0; memError = 0;
        isLoad = 0; isStore = 0; isJAL = 0; isJALR = 0; isBranch = 0; isECALL = 0;
        isEBREAK = 0; isRET = 0; invalidInstruction = 0; rdIndex = 0; jumpTaken = 0;
        jumpTarget = 0; retAddress = 0; trapVector = 0;
    endtask

    task automatic drive_decode(input instr_t t);
        isLoad             = (t.kind == K_LOAD);
        isStore            = (t.kind == K_STORE);
        isBranch           = (t.kind inside {K_BR_NT, K_BR_T});
        isJAL              = (t.kind == K_JAL);
        isJALR             = (t.kind == K_JALR);
        isRET              = (t.kind == K_RET);
        isECALL            = (t.kind == K_ECALL);
        isEBREAK           = (t.kind == K_EBREAK);
        invalidInstruction = (t.kind == K_INVALID);
        jumpTaken          = (t.kind inside {K_BR_T, K_JAL, K_JALR});
        rdIndex            = t.rd;
        jumpTarget         = t.tgt;
        retAddress         = t.reta;
        trapVector         = t.tvec;
    endtask

    task automatic apply_reset(input bit halt_at_release);
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        haltRequest = halt_at_release;
        @(negedge clk);
        check("rst_instr_req", 32'(instrReq), 0);
        check("rst_instr_addr", instrAddr, RESET_PC);
        check("rst_cur_instr", currentInstruction, 0);
        check("rst_is_nop", 32'(isNOP), 1);
        check("rst_strobes", 32'({memReq, regWriteEnable, retire, trapRequest, halted}), 0);
        check("rst_trap_info", 32'(trapCause) | trapPC, 0);
        rst_n = 1;
        m_pc  = RESET_PC;
    endtask

    task automatic do_instr(input instr_t t);
        logic [31:0] data;
        bit          exp_trap;
        logic [3:0]  exp_cause;
        bit          exp_we;
        logic [31:0] exp_next;
        bit          to_mem;
        bit          saw_req;
        int          cyc;

        drive_decode(t);
        data      = (t.kind == K_INVALID) ? 32'hFFFF_FFFF : $urandom;
        to_mem    = 1'b0;
        exp_we    = 1'b0;
        exp_cause = 4'd0;
        exp_trap  = 1'b1;
        if (m_pc[1:0] != 2'b00)          exp_cause = 4'd0;
        else if (t.flat == 0)            exp_cause = 4'd1;
        else if (t.kind == K_INVALID)    exp_cause = 4'd2;
        else if (t.kind == K_ECALL)      exp_cause = 4'd11;
        else if (t.kind == K_EBREAK)     exp_cause = 4'd3;
        else if (t.kind inside {K_LOAD, K_STORE}) begin
            to_mem    = 1'b1;
            exp_trap  = (t.mlat == 0) || t.merr;
            exp_cause = (t.kind == K_STORE) ? 4'd7 : 4'd5;
        end else begin
            exp_trap = 1'b0;
        end
        if (exp_trap) begin
            exp_next = t.tvec;
        end else begin
            exp_we   = (t.rd != 0) && !(t.kind inside {K_STORE, K_BR_NT, K_BR_T});
            exp_next = (t.kind inside {K_BR_T, K_JAL, K_JALR}) ? t.tgt :
                       (t.kind == K_RET) ? t.reta : m_pc + 32'd4;
        end

        if (m_pc[1:0] != 2'b00) begin
            saw_req = 0;
            cyc = 0;
            while (!trapRequest && cyc < 6) begin
                saw_req |= instrReq;
                @(negedge clk);
                cyc++;
            end
            check("misaligned_no_fetch", 32'(saw_req), 0);
        end else begin
            cyc = 0;
            while (!instrReq && cyc < 6) begin
                @(negedge clk);
                cyc++;
            end
            check("fetch_req", 32'(instrReq), 1);
            check("fetch_addr", instrAddr, m_pc);
            cyc = 0;
            while (instrReq && cyc < 300) begin
                cyc++;
                instrAck  = (cyc == t.flat);
                instrData = (cyc == t.flat) ? data : $urandom;
                memAck    = 1'($urandom_range(0, 1));
                memError  = 1'($urandom_range(0, 1));
                @(negedge clk);
                instrAck = 0; memAck = 0; memError = 0;
            end
            check("fetch_cycles", cyc, (t.flat == 0) ? 255 : t.flat);
            if (t.flat != 0) begin
                check("current_instr", currentInstruction, data);
                check("decode_live", 32'(isNOP), 0);
            end
            if (to_mem) begin
                cyc = 0;
                while (!memReq && cyc < 6) begin
                    @(negedge clk);
                    cyc++;
                end
                check("mem_req", 32'(memReq), 1);
                cyc = 0;
                while (memReq && cyc < 300) begin
                    cyc++;
                    if (t.halt_mem) haltRequest = 1;
                    memAck   = (cyc == t.mlat);
                    memError = (cyc == t.mlat) ? t.merr : 1'($urandom_range(0, 1));
                    instrAck = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    memAck = 0; memError = 0; instrAck = 0;
                end
                check("mem_cycles", cyc, (t.mlat == 0) ? 255 : t.mlat);
            end
        end

        cyc = 0;
        while (!(retire || trapRequest) && cyc < 8) begin
            @(negedge clk);
            cyc++;
        end
        check("retire", 32'(retire), 32'(!exp_trap));
        check("trap_request", 32'(trapRequest), 32'(exp_trap));
        check("reg_write", 32'(regWriteEnable), 32'(exp_we));
        if (exp_trap) begin
            check("trap_cause", 32'(trapCause), 32'(exp_cause));
            check("trap_pc", trapPC, m_pc);
        end else begin
            last_retire_cycle = cycle_count;
        end
        m_pc = exp_next;
        @(negedge clk);
        check("single_pulse", 32'({retire, trapRequest, regWriteEnable}), 0);
        if (t.halt_mem) begin
            check("halted", 32'(halted), 1);
            saw_req = 0;
            repeat (3) begin
                saw_req |= instrReq | memReq;
                @(negedge clk);
            end
            check("halted_no_req", 32'(saw_req), 0);
            check("halted_hold", 32'(halted), 1);
            haltRequest = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        instr_t t;
        int     t1;
        int     cyc;

        rst_n = 0;
        idle_inputs();
        apply_reset(1'b0);

        do_instr(mk(K_ALU, 5'd1, 1, 1, 0, 0, 32'h40));
        t1 = last_retire_cycle;
        do_instr(mk(K_ALU, 5'd2, 1, 1, 0, 0, 32'h40));
        check("cycles_per_instr", last_retire_cycle - t1, 4);

        do_instr(mk(K_LOAD,  5'd3, 1, 3, 0, 0, 32'h40));
        do_instr(mk(K_LOAD,  5'd4, 2, 2, 1, 0, 32'h100));
        do_instr(mk(K_STORE, 5'd5, 1, 1, 1, 0, 32'h180));
        do_instr(mk(K_STORE, 5'd6, 1, 2, 0, 0, 32'h180));
        do_instr(mk(K_INVALID, 5'd1, 1, 1, 0, 0, 32'h200));
        do_instr(mk(K_ECALL,   5'd1, 1, 1, 0, 0, 32'h240));
        do_instr(mk(K_EBREAK,  5'd1, 1, 1, 0, 0, 32'h280));
        do_instr(mk(K_BR_NT,   5'd7, 1, 1, 0, 32'h900, 32'h280));
        do_instr(mk(K_RET,     5'd0, 1, 1, 0, 0, 32'h280));

        do_instr(mk(K_JAL, 5'd1, 1, 1, 0, 32'h102, 32'h300));
        do_instr(mk(K_ALU, 5'd2, 1, 1, 0, 0, 32'h300));

        do_instr(mk(K_LOAD, 5'd7, 1, 0,   0, 0, 32'h400));
        do_instr(mk(K_LOAD, 5'd7, 1, 255, 0, 0, 32'h400));
        do_instr(mk(K_ALU,  5'd8, 0, 1,   0, 0, 32'h500));

        do_instr(mk(K_JAL, 5'd0, 1, 1, 0, 32'hFFFF_FFFC, 32'h500));
        do_instr(mk(K_ALU, 5'd9, 1, 1, 0, 0, 32'h500));
        do_instr(mk(K_ALU, 5'd9, 1, 1, 0, 0, 32'h500));

        t = mk(K_LOAD, 5'd10, 1, 2, 0, 0, 32'h600);
        t.halt_mem = 1'b1;
        do_instr(t);
        do_instr(mk(K_ALU, 5'd11, 2, 1, 0, 0, 32'h600));

        drive_decode(mk(K_ALU, 5'd3, 1, 1, 0, 0, 32'h600));
        cyc = 0;
        while (!instrReq && cyc < 6) begin
            @(negedge clk);
            cyc++;
        end
        check("pre_reset_fetch", 32'(instrReq), 1);
        #2 rst_n = 0;
        #1;
        check("async_drop_req", 32'(instrReq), 0);
        check("async_pc", instrAddr, RESET_PC);
        check("async_is_nop", 32'(isNOP), 1);
        instrAck  = 1;
        instrData = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        instrAck = 0;
        m_pc = RESET_PC;
        do_instr(mk(K_ALU, 5'd12, 1, 1, 0, 0, 32'h700));

        apply_reset(1'b1);
        @(negedge clk);
        @(negedge clk);
        check("halt_at_release", 32'(halted), 1);
        check("halt_no_fetch", 32'(instrReq), 0);
        haltRequest = 0;
        do_instr(mk(K_ALU, 5'd13, 1, 1, 0, 0, 32'h700));

        repeat (150) do_instr(rnd_instr());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
